sha256_msg_schedule: RTL and testbench

Message-schedule generator for the SHA-256 core. It accepts one 512-bit block as sixteen 32-bit big-endian words and emits the 64 schedule words W_0..W_63 in order. Those words are the per-round W input of the compression round, which contains ch/maj/Σ0/Σ1. The block is the producer side of the round block's W interface. Internally it reuses the small-sigma functions s0 (σ0) and s1 (σ1).

---
 rtl/sha256_msg_schedule_if.sv | 22 ++
 rtl/sha256_msg_schedule.sv | 86 ++++++++
 tb/tb_sha256_msg_schedule.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_msg_schedule_if.sv
// Word-stream handshake between the message source, the schedule generator and the round block.
// master drives message words and consumes W; slave is the schedule generator.
interface sha256_msg_schedule_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [5:0]  out_idx;
    logic        out_last;

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_word, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_word, out_idx, out_last
    );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads M_0..M_15, then emits W_0..W_63 from a 16-word
// sliding window that is shifted on every accepted input or output word.
module sha256_msg_schedule (
    input  logic                        clk,
    input  logic                        rst_n,
    sha256_msg_schedule_if.slave        bus
);

    typedef enum logic {StLoad, StEmit} state_e;

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] win_q [16];

    logic        in_acc;
    logic        out_acc;
    logic        shift;
    logic [31:0] next_w;
    logic [31:0] shift_word;

    function automatic logic [31:0] s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // Window invariant: win_q[k] = W_{t+k}, so the appended word is W_{t+16}.
    always_comb begin
        next_w     = s1(win_q[14]) + win_q[9] + s0(win_q[1]) + win_q[0];
        in_acc     = (state_q == StLoad) && bus.in_valid;
        out_acc    = (state_q == StEmit) && bus.out_ready;
        shift      = in_acc || out_acc;
        shift_word = in_acc ? bus.in_word : next_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StLoad;
            cnt_q   <= '0;
            for (int k = 0; k < 16; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            if (shift) begin
                for (int k = 0; k < 15; k++) begin
                    win_q[k] <= win_q[k+1];
                end
                win_q[15] <= shift_word;
            end
            unique case (state_q)
                StLoad: begin
                    if (bus.in_valid) begin
                        if (cnt_q == 6'd15) begin
                            cnt_q   <= '0;
                            state_q <= StEmit;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
                StEmit: begin
                    if (bus.out_ready) begin
                        if (cnt_q == 6'd63) begin
                            cnt_q   <= '0;
                            state_q <= StLoad;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
            endcase
        end
    end

    // All outputs come straight from the state, counter and window registers.
    always_comb begin
        bus.in_ready  = (state_q == StLoad);
        bus.out_valid = (state_q == StEmit);
        bus.out_word  = win_q[0];
        bus.out_idx   = cnt_q;
        bus.out_last  = (state_q == StEmit) && (cnt_q == 6'd63);
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule: random and directed blocks compared against
// a textbook SHA-256 schedule model, with backpressure, input gaps and asynchronous resets.
module tb_sha256_msg_schedule;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sha256_msg_schedule_if bus ();

    sha256_msg_schedule dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] msg [16];
    logic [31:0] ref_w [64];
    logic [31:0] got [64];
    logic [5:0]  got_idx [64];
    logic        got_last [64];
    int          n;
    int          cycles;
    int          stall_seen;
    bit          stall_ok;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int sh);
        return (x >> sh) | (x << (32 - sh));
    endfunction

    // Reference: W_t = sigma1(W_{t-2}) + W_{t-7} + sigma0(W_{t-15}) + W_{t-16}
    task automatic model();
        logic [31:0] a;
        logic [31:0] b;
        for (int t = 0; t < 16; t++) ref_w[t] = msg[t];
        for (int t = 16; t < 64; t++) begin
            a = rotr(ref_w[t-15], 7) ^ rotr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3);
            b = rotr(ref_w[t-2], 17) ^ rotr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10);
            ref_w[t] = b + ref_w[t-7] + a + ref_w[t-16];
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) msg[i] = $urandom;
    endtask

    // Called and returns at posedge+1; gap_after drops in_valid for 3 cycles after that word.
    task automatic load_block(input int first, input int last, input int gap_after);
        for (int i = first; i <= last; i++) begin
            bus.in_valid = 1'b1;
            bus.in_word  = msg[i];
            @(posedge clk);
            #1;
            if (i == gap_after) begin
                bus.in_valid = 1'b0;
                bus.in_word  = 32'hdeadbeef;
                repeat (3) @(posedge clk);
                #1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    // mode 0: out_ready=1, 1: random out_ready, 2: 5-cycle stall at index stall_at
    task automatic collect(input int mode, input int stall_at);
        logic [31:0] hw;
        logic [5:0]  hi;
        logic        hl;
        n = 0;
        cycles = 0;
        stall_ok = 1'b1;
        stall_seen = 0;
        while (n < 64 && cycles < 2000) begin
            case (mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (bus.out_valid && bus.out_idx == 6'(stall_at) && stall_seen < 5) begin
                        if (stall_seen == 0) begin
                            hw = bus.out_word;
                            hi = bus.out_idx;
                            hl = bus.out_last;
                        end
                        bus.out_ready = 1'b0;
                        stall_seen++;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                end
            endcase
            @(negedge clk);
            if (mode == 2 && !bus.out_ready && stall_seen > 0 &&
                (bus.out_word !== hw || bus.out_idx !== hi || bus.out_last !== hl)) begin
                stall_ok = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                got[n]      = bus.out_word;
                got_idx[n]  = bus.out_idx;
                got_last[n] = bus.out_last;
                n++;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_word   = 32'h0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_word !== 32'h0 ||
            bus.out_idx !== 6'd0 || bus.out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got rdy=%b vld=%b word=%h idx=%0d last=%b exp 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_word, bus.out_idx, bus.out_last);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_block();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        model();
        load_block(0, 14, -1);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_early_valid got %b exp 0", bus.out_valid);
        end
        load_block(15, 15, -1);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_idx !== 6'd0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL zero_valid_rise got vld=%b idx=%0d rdy=%b exp 1 0 0",
                     bus.out_valid, bus.out_idx, bus.in_ready);
        end
        @(posedge clk);
        #1;
        collect(0, 0);
        checks++;
        if (n != 64 || cycles != 64) begin
            failures++;
            $display("FAIL zero_count got words=%0d cycles=%0d exp 64 64", n, cycles);
        end
        for (int t = 0; t < n; t++) begin
            checks++;
            if (got[t] !== 32'h0 || got_idx[t] !== 6'(t) || got_last[t] !== (t == 63)) begin
                failures++;
                $display("FAIL zero_seq t=%0d got %h/%0d/%b exp 00000000/%0d/%b",
                         t, got[t], got_idx[t], got_last[t], t, t == 63);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_back_to_load got rdy=%b vld=%b exp 1 0", bus.in_ready,
                     bus.out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sigma();
        logic [31:0] exp16;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 16; i++) msg[i] = 32'h0;
            if (c == 0) msg[1] = 32'h00000010;
            else msg[14] = 32'h00000010;
            exp16 = (c == 0) ? 32'h20040002 : 32'h000a0000;
            model();
            load_block(0, 15, -1);
            collect(0, 0);
            checks++;
            if (n != 64 || got[(c == 0) ? 1 : 14] !== 32'h00000010 || got[16] !== exp16) begin
                failures++;
                $display("FAIL sigma_case%0d got n=%0d w_in=%h w16=%h exp 64 00000010 %h",
                         c, n, got[(c == 0) ? 1 : 14], got[16], exp16);
            end
            for (int t = 0; t < n; t++) begin
                checks++;
                if (got[t] !== ref_w[t] || got_idx[t] !== 6'(t)) begin
                    failures++;
                    $display("FAIL sigma_seq%0d t=%0d got %h/%0d exp %h/%0d",
                             c, t, got[t], got_idx[t], ref_w[t], t);
                end
            end
        end
    endtask

    task automatic test_abc();
        set_abc();
        model();
        load_block(0, 15, -1);
        collect(0, 0);
        checks++;
        if (n != 64 || got[16] !== 32'h61626380 || got[17] !== 32'h000f0000 ||
            got[18] !== 32'h7da86405) begin
            failures++;
            $display("FAIL abc_known got n=%0d %h %h %h exp 64 61626380 000f0000 7da86405",
                     n, got[16], got[17], got[18]);
        end
        for (int t = 0; t < n; t++) begin
            checks++;
            if (got[t] !== ref_w[t] || got_idx[t] !== 6'(t) || got_last[t] !== (t == 63)) begin
                failures++;
                $display("FAIL abc_seq t=%0d got %h/%0d/%b exp %h/%0d/%b",
                         t, got[t], got_idx[t], got_last[t], ref_w[t], t, t == 63);
            end
        end
    endtask

    task automatic test_backpressure();
        set_random();
        model();
        load_block(0, 15, 7);
        collect(2, 20);
        checks++;
        if (n != 64 || stall_seen != 5 || !stall_ok || cycles != 69) begin
            failures++;
            $display("FAIL stall got n=%0d stalls=%0d stable=%b cycles=%0d exp 64 5 1 69",
                     n, stall_seen, stall_ok, cycles);
        end
        for (int t = 0; t < n; t++) begin
            checks++;
            if (got[t] !== ref_w[t] || got_idx[t] !== 6'(t)) begin
                failures++;
                $display("FAIL gap_stall_seq t=%0d got %h/%0d exp %h/%0d",
                         t, got[t], got_idx[t], ref_w[t], t);
            end
        end
    endtask

    task automatic test_random_ready();
        for (int b = 0; b < 3; b++) begin
            set_random();
            model();
            load_block(0, 15, -1);
            // in_valid with garbage during emit must be ignored
            bus.in_valid = 1'b1;
            bus.in_word  = $urandom;
            collect(1, 0);
            bus.in_valid = 1'b0;
            checks++;
            if (n != 64) begin
                failures++;
                $display("FAIL rand_ready_count blk=%0d got %0d exp 64", b, n);
            end
            for (int t = 0; t < n; t++) begin
                checks++;
                if (got[t] !== ref_w[t] || got_idx[t] !== 6'(t) || got_last[t] !== (t == 63)) begin
                    failures++;
                    $display("FAIL rand_ready_seq blk=%0d t=%0d got %h/%0d exp %h/%0d",
                             b, t, got[t], got_idx[t], ref_w[t], t);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        // c=0: reset at emit index 30, c=1: reset after 9 loaded words
        for (int c = 0; c < 2; c++) begin
            set_random();
            if (c == 0) begin
                load_block(0, 15, -1);
                bus.out_ready = 1'b1;
                cycles = 0;
                @(negedge clk);
                while (!(bus.out_valid && bus.out_idx == 6'd30) && cycles < 200) begin
                    @(negedge clk);
                    cycles++;
                end
                checks++;
                if (cycles >= 200) begin
                    failures++;
                    $display("FAIL reset_reach_idx30 got timeout exp idx 30");
                end
                rst_n = 1'b0;
                #1;
            end else begin
                load_block(0, 8, -1);
                pulse_reset();
            end
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_idx !== 6'd0 ||
                bus.out_word !== 32'h0) begin
                failures++;
                $display("FAIL reset_async%0d got vld=%b rdy=%b idx=%0d word=%h exp 0 1 0 0",
                         c, bus.out_valid, bus.in_ready, bus.out_idx, bus.out_word);
            end
            release_reset();
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_release%0d got rdy=%b vld=%b exp 1 0", c, bus.in_ready,
                         bus.out_valid);
            end
            @(posedge clk);
            #1;
            set_abc();
            model();
            load_block(0, 15, -1);
            collect(0, 0);
            checks++;
            if (n != 64) begin
                failures++;
                $display("FAIL reset_abc_count%0d got %0d exp 64", c, n);
            end
            for (int t = 0; t < n; t++) begin
                checks++;
                if (got[t] !== ref_w[t] || got_idx[t] !== 6'(t)) begin
                    failures++;
                    $display("FAIL reset_abc_seq%0d t=%0d got %h/%0d exp %h/%0d",
                             c, t, got[t], got_idx[t], ref_w[t], t);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_block();
        test_sigma();
        test_abc();
        test_backpressure();
        test_random_ready();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
